// File: rtl/tqvp_hx2003_pulse_receiver.sv
// Pulse-width receiver: classifies each line period as short/long per level and
// packs the 2-bit symbols into 16-symbol words with a valid/ready handoff.
//   state     | meaning
//   IDLE      | disabled, overflow cleared
//   WAIT_EDGE | line at idle level, waiting for a frame to start
//   MEASURE   | timing periods, recording symbols at each edge
module tqvp_hx2003_pulse_receiver #(
  parameter int DUR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  input  logic             cfg_invert,
  input  logic             cfg_idle_level,
  input  logic [3:0]       cfg_prescaler,
  input  logic [DUR_W-1:0] cfg_thresh_low,
  input  logic [DUR_W-1:0] cfg_thresh_high,
  input  logic [DUR_W-1:0] cfg_idle_timeout,
  output logic [31:0]      word_data,
  output logic [4:0]       word_count,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             frame_done,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE} state_t;

  state_t           state, state_next;
  logic             level, level_q, edge_det;
  logic [14:0]      presc, presc_max;
  logic [15:0]      presc_full;
  logic             tick;
  logic [DUR_W-1:0] dur, dur_inc, thresh;
  logic [3:0]       slot;
  logic [31:0]      shift, shift_next, new_data;
  logic [4:0]       new_count;
  logic [1:0]       symbol;
  logic             start, sym_write, timeout_hit, new_word;

  assign level      = sig_in ^ cfg_invert;
  assign edge_det   = level != level_q;
  assign presc_full = (16'd1 << cfg_prescaler) - 16'd1;
  assign presc_max  = presc_full[14:0];
  assign tick       = presc == presc_max;
  // A tick landing on the edge cycle still counts toward the finished period.
  assign dur_inc    = (tick && dur != '1) ? dur + DUR_W'(1) : dur;
  assign thresh     = level_q ? cfg_thresh_high : cfg_thresh_low;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:      state_next = WAIT_EDGE;
        WAIT_EDGE: if (start) state_next = MEASURE;
        MEASURE:   if (timeout_hit) state_next = WAIT_EDGE;
        default:   state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    start       = (state == WAIT_EDGE) && en && (level != cfg_idle_level);
    sym_write   = (state == MEASURE) && en && edge_det;
    timeout_hit = (state == MEASURE) && en && !edge_det && (cfg_idle_timeout != '0) &&
                  (level_q == cfg_idle_level) && (dur == cfg_idle_timeout);
    symbol      = {level_q, dur_inc > thresh};
    // Writing slot 0 starts a fresh word, so unused upper slots read as zero.
    shift_next  = ((slot == 4'd0) ? 32'd0 : shift) | (32'(symbol) << {slot, 1'b0});
    new_word    = (sym_write && slot == 4'd15) || (timeout_hit && slot != 4'd0);
    new_data    = sym_write ? shift_next : shift;
    new_count   = sym_write ? 5'd16 : {1'b0, slot};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q    <= 1'b0;
      presc      <= '0;
      dur        <= '0;
      slot       <= '0;
      shift      <= '0;
      frame_done <= 1'b0;
      word_valid <= 1'b0;
      word_data  <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      level_q    <= level;
      frame_done <= timeout_hit;
      if (start) begin
        presc <= '0;
        dur   <= '0;
        slot  <= '0;
      end else if (sym_write) begin
        shift <= shift_next;
        slot  <= slot + 4'd1;
        presc <= '0;
        dur   <= '0;
      end else if (state == MEASURE) begin
        presc <= tick ? 15'd0 : presc + 15'd1;
        dur   <= dur_inc;
      end
      if (word_valid && word_ready) word_valid <= 1'b0;
      if (new_word) begin
        if (!word_valid || word_ready) begin
          word_valid <= 1'b1;
          word_data  <= new_data;
          word_count <= new_count;
        end else begin
          overflow <= 1'b1;
        end
      end
      if (state == IDLE) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tqvp_hx2003_pulse_receiver.sv
// Bench for the pulse receiver: period-length reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_tqvp_hx2003_pulse_receiver;
  localparam int DUR_W = 8;

  logic             clk = 1'b0;
  logic             rst_n, en, sig_in, cfg_invert, cfg_idle_level, word_ready;
  logic [3:0]       cfg_prescaler;
  logic [DUR_W-1:0] cfg_thresh_low, cfg_thresh_high, cfg_idle_timeout;
  logic [31:0]      word_data;
  logic [4:0]       word_count;
  logic             word_valid, frame_done, overflow;

  tqvp_hx2003_pulse_receiver #(.DUR_W(DUR_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in), .cfg_invert(cfg_invert),
    .cfg_idle_level(cfg_idle_level), .cfg_prescaler(cfg_prescaler),
    .cfg_thresh_low(cfg_thresh_low), .cfg_thresh_high(cfg_thresh_high),
    .cfg_idle_timeout(cfg_idle_timeout), .word_data(word_data), .word_count(word_count),
    .word_valid(word_valid), .word_ready(word_ready), .frame_done(frame_done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit rnd_ready = 0;

  // model: 0 disabled, 1 waiting for frame, 2 in frame
  int          m_st = 0;
  bit          m_lvl;
  int          m_n;
  int          syms[$];
  bit          m_vld, m_fd, m_ovf;
  logic [31:0] m_data;
  int          m_cnt;

  logic [31:0] words_data[$];
  int          words_cnt[$];
  int          fd_cnt = 0;
  bit          vld_d = 0, acc_d = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit lvl, nw;
    int d, r, th, dmax, st_before;
    logic [31:0] wd;
    lvl  = sig_in ^ cfg_invert;
    dmax = (1 << DUR_W) - 1;
    if (!rst_n) begin
      m_st = 0; m_vld = 0; m_fd = 0; m_ovf = 0; m_data = 0; m_cnt = 0;
      syms.delete();
      return;
    end
    nw = 0; wd = 0; st_before = m_st; m_fd = 0;
    if (m_vld && word_ready) m_vld = 0;
    if (!en) m_st = 0;
    else if (m_st == 0) m_st = 1;
    else if (m_st == 1) begin
      if (lvl != cfg_idle_level) begin
        m_st = 2; m_n = 0; m_lvl = lvl; syms.delete();
      end
    end else begin
      m_n++;
      r = (m_n - 1) >> cfg_prescaler;
      if (r > dmax) r = dmax;
      if (lvl != m_lvl) begin
        d = m_n >> cfg_prescaler;
        if (d > dmax) d = dmax;
        th = m_lvl ? int'(cfg_thresh_high) : int'(cfg_thresh_low);
        syms.push_back(2 * int'(m_lvl) + ((d > th) ? 1 : 0));
        m_lvl = lvl; m_n = 0;
        if (syms.size() == 16) nw = 1;
      end else if (cfg_idle_timeout != 0 && m_lvl == cfg_idle_level && r == int'(cfg_idle_timeout)) begin
        m_fd = 1; m_st = 1;
        if (syms.size() > 0) nw = 1;
      end
    end
    if (nw) begin
      foreach (syms[i]) wd = wd | (32'(syms[i]) << (2 * i));
      if (!m_vld) begin
        m_vld = 1; m_data = wd; m_cnt = syms.size();
      end else m_ovf = 1;
      syms.delete();
    end else if (m_fd) syms.delete();
    if (st_before == 0) m_ovf = 0;
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("word_valid", 32'(word_valid), 32'(m_vld));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("word_data", word_data, m_data);
    chk("word_count", 32'(word_count), 32'(m_cnt));
    if (word_valid && !(vld_d && !acc_d)) begin
      words_data.push_back(word_data);
      words_cnt.push_back(int'(word_count));
    end
    if (frame_done) fd_cnt++;
    vld_d = word_valid;
    acc_d = word_valid && word_ready;
  end

  task automatic hold(bit v, int k);
    sig_in = v;
    repeat (k) begin
      if (rnd_ready) word_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  task automatic hold_lvl(bit l, int k);
    hold(l ^ cfg_invert, k);
  endtask

  task automatic set_cfg(int p, int tl, int th, int to, bit idle, bit inv);
    en = 0;
    cfg_prescaler = 4'(p); cfg_thresh_low = DUR_W'(tl); cfg_thresh_high = DUR_W'(th);
    cfg_idle_timeout = DUR_W'(to); cfg_idle_level = idle; cfg_invert = inv;
    sig_in = idle ^ inv;
    repeat (2) @(negedge clk);
    words_data.delete(); words_cnt.delete(); fd_cnt = 0;
    en = 1;
  endtask

  task automatic expect_word(string name, int idx, logic [31:0] data, int cnt);
    if (words_data.size() > idx) begin
      chk({name, "_data"}, words_data[idx], data);
      chk({name, "_count"}, 32'(words_cnt[idx]), 32'(cnt));
    end else chk({name, "_missing"}, 32'(words_data.size()), 32'(idx + 1));
  endtask

  task automatic run_basic();
    hold(0, 3); hold(1, 3); hold(0, 8); hold(1, 6); hold(0, 30);
  endtask

  initial begin
    rst_n = 0; en = 0; sig_in = 0; word_ready = 1;
    cfg_invert = 0; cfg_idle_level = 0; cfg_prescaler = 0;
    cfg_thresh_low = 4; cfg_thresh_high = 4; cfg_idle_timeout = 20;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(word_valid), 0);
    chk("rst_data", word_data, 0);
    chk("rst_count", 32'(word_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst_n = 1;

    set_cfg(0, 4, 4, 20, 0, 0);
    run_basic();
    chk("basic_words", 32'(words_data.size()), 1);
    expect_word("basic", 0, 32'h36, 3);
    chk("basic_fd", 32'(fd_cnt), 1);

    set_cfg(0, 4, 4, 20, 0, 0);
    hold(0, 2);
    repeat (8) begin hold(1, 2); hold(0, 2); end
    hold(1, 2); hold(0, 30);
    expect_word("alt16", 0, 32'h22222222, 16);
    expect_word("alt16_tail", 1, 32'h2, 1);

    set_cfg(0, 4, 4, 20, 0, 0);
    word_ready = 0;
    hold(0, 2);
    repeat (16) begin hold(1, 2); hold(0, 2); end
    hold(1, 2); hold(0, 30);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_held", word_data, 32'h22222222);
    chk("ovf_words", 32'(words_data.size()), 1);
    word_ready = 1;
    hold(0, 3);
    en = 0;
    hold(0, 3);
    chk("ovf_cleared", 32'(overflow), 0);

    set_cfg(2, 4, 2, 3, 0, 0);
    hold(0, 3); hold(1, 12); hold(0, 40);
    expect_word("presc_th2", 0, 32'h3, 1);
    set_cfg(2, 4, 3, 3, 0, 0);
    hold(0, 3); hold(1, 12); hold(0, 40);
    expect_word("presc_th3", 0, 32'h2, 1);

    set_cfg(0, 4, 4, 20, 1, 1);
    hold(0, 3); hold(1, 3); hold(0, 8); hold(1, 6); hold(0, 30);
    expect_word("invert", 0, 32'h1C, 3);

    set_cfg(0, 4, 4, 20, 0, 0);
    hold(0, 3); hold(1, 3); hold(0, 5);
    en = 0;
    hold(0, 4);
    chk("abort_words", 32'(words_data.size()), 0);
    chk("abort_fd", 32'(fd_cnt), 0);
    en = 1;
    run_basic();
    expect_word("rerun", 0, 32'h36, 3);

    set_cfg(0, 4, 254, 20, 0, 0);
    hold(0, 3); hold(1, 300); hold(0, 30);
    expect_word("saturate", 0, 32'h3, 1);

    set_cfg(0, 4, 4, 5, 0, 0);
    hold(0, 3); hold(1, 3); hold(0, 6); hold(1, 3); hold(0, 20);
    expect_word("edge_wins", 0, 32'h26, 3);
    chk("edge_wins_fd", 32'(fd_cnt), 1);

    rnd_ready = 1;
    for (int f = 0; f < 30; f++) begin
      int p, to, np;
      bit l;
      p  = $urandom_range(0, 2);
      to = $urandom_range(2, 12);
      set_cfg(p, $urandom_range(1, 8), $urandom_range(1, 8), to,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      hold_lvl(cfg_idle_level, 2);
      l  = !cfg_idle_level;
      np = $urandom_range(1, 40);
      for (int i = 0; i < np; i++) begin
        hold_lvl(l, $urandom_range(1, 12));
        l = !l;
      end
      hold_lvl(cfg_idle_level, ((to + 1) << p) + 5);
    end
    rnd_ready = 0;
    word_ready = 1;
    hold(sig_in, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tqvp_hx2003_pulse_receiver.md
TQVP_HX2003_PULSE_RECEIVER -- requirements
Module: tqvp_hx2003_pulse_receiver

Interface
REQ-001 SHALL have parameter DUR_W, default 8, giving the duration counter and threshold width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock for all state.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port en, input, 1 bit: receiver enable; low aborts and holds the block idle.
REQ-005 SHALL have port sig_in, input, 1 bit: pulse input, already synchronous to clk.
REQ-006 SHALL have port cfg_invert, input, 1 bit: level = sig_in XOR cfg_invert.
REQ-007 SHALL have port cfg_idle_level, input, 1 bit: line level between frames.
REQ-008 SHALL have port cfg_prescaler, input, 4 bits: one tick every 2^cfg_prescaler clocks.
REQ-009 SHALL have ports cfg_thresh_low and cfg_thresh_high, input, DUR_W bits each: long/short boundary per level.
REQ-010 SHALL have port cfg_idle_timeout, input, DUR_W bits: idle ticks that end a frame; 0 disables the timeout.
REQ-011 SHALL have port word_data, output, 32 bits: packed symbols, symbol n at bits [2n+1:2n].
REQ-012 SHALL have port word_count, output, 5 bits: number of valid symbols in word_data (1..16).
REQ-013 SHALL have ports word_valid (output) and word_ready (input), 1 bit each: output handshake.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse at frame end.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag set when a word is dropped.

Function
REQ-016 SHALL implement states IDLE, WAIT_EDGE and MEASURE; en low in any state forces IDLE on the next edge.
REQ-017 IDLE -> WAIT_EDGE SHALL occur on the first cycle en is high; entering WAIT_EDGE loads level_q = level.
REQ-018 level_q SHALL register level every cycle; an edge is level != level_q.
REQ-019 WAIT_EDGE -> MEASURE SHALL occur on a cycle where level != cfg_idle_level; that cycle clears the prescaler count, dur and slot.
REQ-020 The prescaler count (15 bits) SHALL produce a tick on the cycle it equals 2^cfg_prescaler-1, then wrap to 0; dur SHALL increment on each tick and saturate at all-ones.
REQ-021 On an edge in MEASURE, the block SHALL form symbol = {level_q, long}, where long = dur > thresh, and thresh = cfg_thresh_high if level_q else cfg_thresh_low.
REQ-022 The same edge cycle SHALL write the symbol into the shift word at slot, increment slot, and clear dur and the prescaler count.
REQ-023 When slot 15 is written, word_data/word_count=16 SHALL be presented with word_valid high on the next cycle; slot SHALL wrap to 0.
REQ-024 In MEASURE with cfg_idle_timeout != 0, level_q == cfg_idle_level and dur == cfg_idle_timeout, the block SHALL end the frame.
REQ-025 On frame end, the block SHALL pulse frame_done for one cycle, return to WAIT_EDGE, and not record the final idle period as a symbol.
REQ-026 On frame end with slot > 0, the block SHALL present the partial word with word_count = slot; unused upper bits SHALL be 0.
REQ-027 word_valid SHALL hold with word_data and word_count stable until a cycle with word_ready high, and SHALL drop on the following edge.
REQ-028 If a new word completes while word_valid is high and word_ready is low, the new word SHALL be discarded and overflow set.
REQ-029 If a new word completes in the same cycle that word_ready accepts the old word, the new word SHALL be accepted and overflow SHALL not be set.
REQ-030 An edge and a timeout in the same cycle SHALL be treated as an edge; the timeout SHALL NOT fire.
REQ-031 overflow SHALL clear only in IDLE.

Reset
REQ-032 While rst_n is low at an edge, state SHALL become IDLE, and word_valid, frame_done, overflow, word_data, word_count, dur, slot, the prescaler count and level_q SHALL become 0.
REQ-033 Reset or en low mid-frame SHALL discard the partial word without asserting frame_done.

Verification
REQ-034 Scenario: prescaler 0, thresholds 4/4, timeout 20, idle 0, word_ready 1; drive high 3 clks, low 8 clks, high 6 clks, then low -> one word with count 3 and data 0x00000036, then frame_done.
REQ-035 Scenario: 16 alternating short pulses -> word_valid one cycle after the 16th edge, count 16, data 0x22222222 (low-short bits 00, high-short bits 10).
REQ-036 Scenario: word_ready 0 through two full words -> the first word is held stable, overflow=1, and the second word is never presented.
REQ-037 Scenario: prescaler 2 and a 12-clock high pulse with thresh_high 2 -> dur=3 and symbol 11; with thresh_high 3 -> symbol 10.
REQ-038 Scenario: cfg_invert=1 and idle_level 1 with sig_in idle low -> the frame starts on the sig_in rising edge, and symbols carry the inverted level.
REQ-039 Scenario: en dropped mid-frame -> no word_valid and no frame_done; re-enable and rerun the first scenario -> identical result.
